// File: rtl/dram_write_bridge.sv
// Packer-to-DDR write bridge: queues {address, data} words from the sample
// packer and issues each one as a single-beat write on the controller app
// interface, with independent command and write-data handshakes.
module dram_write_bridge #(
    parameter int unsigned MEM_IF_WIDTH  = 128,
    parameter int unsigned ADX_WIDTH     = 27,
    parameter int unsigned FIFO_AW       = 2,
    parameter logic [2:0]  APP_CMD_WRITE = 3'b000
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      write_req,
    input  logic [MEM_IF_WIDTH-1:0]   dram_data,
    input  logic [ADX_WIDTH-1:0]      dram_adx,
    output logic                      write_allowed,
    input  logic                      init_calib_complete,
    output logic                      app_en,
    output logic [2:0]                app_cmd,
    output logic [ADX_WIDTH-1:0]      app_addr,
    input  logic                      app_rdy,
    output logic [MEM_IF_WIDTH-1:0]   app_wdf_data,
    output logic                      app_wdf_wren,
    output logic                      app_wdf_end,
    output logic [MEM_IF_WIDTH/8-1:0] app_wdf_mask,
    input  logic                      app_wdf_rdy,
    output logic [FIFO_AW:0]          fifo_level,
    output logic                      overflow,
    output logic [31:0]               writes_done
);

    localparam int unsigned DEPTH  = 1 << FIFO_AW;
    localparam int unsigned LVL_W  = FIFO_AW + 1;
    localparam int unsigned PTR_W  = FIFO_AW;
    localparam int unsigned MASK_W = MEM_IF_WIDTH / 8;

    typedef enum logic [1:0] {
        WAIT_CALIB = 2'd0,
        IDLE       = 2'd1,
        ISSUE      = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    // Queue storage; contents are don't-care until written, so no reset.
    logic [ADX_WIDTH-1:0]    adx_mem  [DEPTH];
    logic [MEM_IF_WIDTH-1:0] data_mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             cmd_done;
    logic             data_done;
    logic             push;
    logic             pop;

    // State register; a falling calibration flag is never looked at again.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= WAIT_CALIB;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake decode from registered state only.
    always_comb begin
        state_nxt     = state;
        app_en        = 1'b0;
        app_wdf_wren  = 1'b0;
        app_wdf_end   = 1'b0;
        pop           = 1'b0;
        write_allowed = (state != WAIT_CALIB) && (fifo_level < LVL_W'(DEPTH));
        push          = write_req & write_allowed;
        case (state)
            WAIT_CALIB: begin
                if (init_calib_complete) begin
                    state_nxt = IDLE;
                end
            end
            IDLE: begin
                if (fifo_level != '0) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                app_en       = ~cmd_done;
                app_wdf_wren = ~data_done;
                app_wdf_end  = ~data_done;
                pop          = cmd_done & data_done;
                if (pop && (fifo_level == LVL_W'(1)) && !push) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = WAIT_CALIB;
            end
        endcase
    end

    // Head entry is always presented; qualified by the valids above.
    assign app_cmd      = APP_CMD_WRITE;
    assign app_addr     = adx_mem[rd_ptr];
    assign app_wdf_data = data_mem[rd_ptr];
    assign app_wdf_mask = MASK_W'(0);

    // Queue write port.
    always_ff @(posedge clk) begin
        if (push) begin
            adx_mem[wr_ptr]  <= dram_adx;
            data_mem[wr_ptr] <= dram_data;
        end
    end

    // Pointers, level, handshake-completion flags and status counters.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_level  <= '0;
            cmd_done    <= 1'b0;
            data_done   <= 1'b0;
            overflow    <= 1'b0;
            writes_done <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr      <= rd_ptr + PTR_W'(1);
                cmd_done    <= 1'b0;
                data_done   <= 1'b0;
                writes_done <= writes_done + 32'd1;
            end else begin
                if (app_en && app_rdy) begin
                    cmd_done <= 1'b1;
                end
                if (app_wdf_wren && app_wdf_rdy) begin
                    data_done <= 1'b1;
                end
            end
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + LVL_W'(1);
                2'b01:   fifo_level <= fifo_level - LVL_W'(1);
                default: fifo_level <= fifo_level;
            endcase
            if (write_req && !write_allowed) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dram_write_bridge.sv
// Directed bench for dram_write_bridge with hand-computed expectations.
module tb_dram_write_bridge;

    logic         clk = 1'b0;
    logic         resetn;
    logic         write_req;
    logic [127:0] dram_data;
    logic [26:0]  dram_adx;
    logic         write_allowed;
    logic         init_calib_complete;
    logic         app_en;
    logic [2:0]   app_cmd;
    logic [26:0]  app_addr;
    logic         app_rdy;
    logic [127:0] app_wdf_data;
    logic         app_wdf_wren;
    logic         app_wdf_end;
    logic [15:0]  app_wdf_mask;
    logic         app_wdf_rdy;
    logic [2:0]   fifo_level;
    logic         overflow;
    logic [31:0]  writes_done;

    int checks = 0;
    int errors = 0;

    logic        mon_en = 1'b0;
    logic [26:0] got_adx [$];

    localparam logic [127:0] D0 = 128'h0123456789ABCDEF0123456789ABCDEF;
    localparam logic [127:0] D1 = 128'hCAFEF00D_11112222_33334444_55556666;
    localparam logic [127:0] D2 = 128'hDEADBEEF_77778888_9999AAAA_BBBBCCCC;

    dram_write_bridge dut (
        .clk                 (clk),
        .resetn              (resetn),
        .write_req           (write_req),
        .dram_data           (dram_data),
        .dram_adx            (dram_adx),
        .write_allowed       (write_allowed),
        .init_calib_complete (init_calib_complete),
        .app_en              (app_en),
        .app_cmd             (app_cmd),
        .app_addr            (app_addr),
        .app_rdy             (app_rdy),
        .app_wdf_data        (app_wdf_data),
        .app_wdf_wren        (app_wdf_wren),
        .app_wdf_end         (app_wdf_end),
        .app_wdf_mask        (app_wdf_mask),
        .app_wdf_rdy         (app_wdf_rdy),
        .fifo_level          (fifo_level),
        .overflow            (overflow),
        .writes_done         (writes_done)
    );

    always #5 clk = ~clk;

    // Record every command address the controller accepts.
    always @(negedge clk) begin
        if (mon_en && app_en && app_rdy) begin
            got_adx.push_back(app_addr);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        resetn = 1'b0; write_req = 1'b0; dram_data = '0; dram_adx = '0;
        init_calib_complete = 1'b0; app_rdy = 1'b0; app_wdf_rdy = 1'b0;

        // Reset with calibration low
        step(); step();
        chk("rst_allowed", 128'(write_allowed), 128'(0));
        chk("rst_app_en", 128'(app_en), 128'(0));
        chk("rst_wren", 128'(app_wdf_wren), 128'(0));
        chk("rst_level", 128'(fifo_level), 128'(0));
        chk("rst_overflow", 128'(overflow), 128'(0));
        chk("rst_done", 128'(writes_done), 128'(0));
        resetn = 1'b1;
        write_req = 1'b1; dram_adx = 27'h0000123;
        step();
        write_req = 1'b0;
        chk("precal_overflow", 128'(overflow), 128'(1));
        chk("precal_level", 128'(fifo_level), 128'(0));
        chk("precal_app_en", 128'(app_en), 128'(0));
        chk("precal_allowed", 128'(write_allowed), 128'(0));
        resetn = 1'b0;
        step();
        chk("rst2_overflow", 128'(overflow), 128'(0));
        resetn = 1'b1;

        // Single write
        init_calib_complete = 1'b1;
        step();
        chk("cal_allowed", 128'(write_allowed), 128'(1));
        app_rdy = 1'b1; app_wdf_rdy = 1'b1;
        write_req = 1'b1; dram_adx = 27'h0000040; dram_data = D0;
        step();
        write_req = 1'b0;
        chk("w1_level", 128'(fifo_level), 128'(1));
        chk("w1_idle_en", 128'(app_en), 128'(0));
        step();
        chk("w1_app_en", 128'(app_en), 128'(1));
        chk("w1_wren", 128'(app_wdf_wren), 128'(1));
        chk("w1_end", 128'(app_wdf_end), 128'(1));
        chk("w1_cmd", 128'(app_cmd), 128'(0));
        chk("w1_mask", 128'(app_wdf_mask), 128'(0));
        chk("w1_addr", 128'(app_addr), 128'(27'h0000040));
        chk("w1_data", app_wdf_data, D0);
        step();
        chk("w1_hs_en", 128'(app_en), 128'(0));
        chk("w1_hs_wren", 128'(app_wdf_wren), 128'(0));
        chk("w1_hs_done", 128'(writes_done), 128'(0));
        step();
        chk("w1_done", 128'(writes_done), 128'(1));
        chk("w1_empty", 128'(fifo_level), 128'(0));
        chk("w1_idle", 128'(app_en), 128'(0));

        // Command late, data first
        app_rdy = 1'b0; app_wdf_rdy = 1'b1;
        write_req = 1'b1; dram_adx = 27'h0000080; dram_data = D1;
        step();
        write_req = 1'b0;
        step();
        chk("cl_en0", 128'(app_en), 128'(1));
        chk("cl_wren0", 128'(app_wdf_wren), 128'(1));
        step();
        chk("cl_wren1", 128'(app_wdf_wren), 128'(0));
        chk("cl_en1", 128'(app_en), 128'(1));
        step();
        chk("cl_en2", 128'(app_en), 128'(1));
        chk("cl_addr", 128'(app_addr), 128'(27'h0000080));
        app_rdy = 1'b1;
        step();
        chk("cl_en3", 128'(app_en), 128'(0));
        chk("cl_pending", 128'(writes_done), 128'(1));
        step();
        chk("cl_done", 128'(writes_done), 128'(2));

        // Data late, command first
        app_rdy = 1'b1; app_wdf_rdy = 1'b0;
        write_req = 1'b1; dram_adx = 27'h00000C0; dram_data = D2;
        step();
        write_req = 1'b0;
        step();
        chk("dl_en0", 128'(app_en), 128'(1));
        step();
        chk("dl_en1", 128'(app_en), 128'(0));
        chk("dl_wren1", 128'(app_wdf_wren), 128'(1));
        chk("dl_data", app_wdf_data, D2);
        step();
        chk("dl_wren2", 128'(app_wdf_wren), 128'(1));
        app_wdf_rdy = 1'b1;
        step();
        chk("dl_wren3", 128'(app_wdf_wren), 128'(0));
        step();
        chk("dl_done", 128'(writes_done), 128'(3));
        chk("dl_empty", 128'(fifo_level), 128'(0));

        // Full queue and overflow
        app_rdy = 1'b0; app_wdf_rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            write_req = 1'b1;
            dram_adx  = 27'h0000100 + 27'(i);
            dram_data = {4{32'hA0000000 + 32'(i)}};
            step();
        end
        write_req = 1'b0;
        chk("full_level", 128'(fifo_level), 128'(4));
        chk("full_allowed", 128'(write_allowed), 128'(0));
        chk("full_no_ovf", 128'(overflow), 128'(0));
        write_req = 1'b1; dram_adx = 27'h00001FF; dram_data = '1;
        step();
        write_req = 1'b0;
        chk("full_ovf", 128'(overflow), 128'(1));
        chk("full_level2", 128'(fifo_level), 128'(4));
        app_rdy = 1'b1; app_wdf_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("full_en", 128'(app_en), 128'(1));
            chk("full_addr", 128'(app_addr), 128'(27'h0000100 + 27'(i)));
            chk("full_data", app_wdf_data, {4{32'hA0000000 + 32'(i)}});
            step(); step();
        end
        chk("full_done", 128'(writes_done), 128'(7));
        chk("full_empty", 128'(fifo_level), 128'(0));
        chk("full_idle", 128'(app_en), 128'(0));

        // Pointer wrap with continuous traffic
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        step();
        mon_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            write_req = 1'b1;
            dram_adx  = 27'(i * 37 + 5);
            dram_data = {4{32'(i)}};
            step();
            write_req = 1'b0;
            step();
        end
        for (int k = 0; k < 40 && writes_done != 32'd20; k++) begin
            step();
        end
        mon_en = 1'b0;
        chk("wrap_done", 128'(writes_done), 128'(20));
        chk("wrap_no_ovf", 128'(overflow), 128'(0));
        chk("wrap_empty", 128'(fifo_level), 128'(0));
        chk("wrap_count", 128'(got_adx.size()), 128'(20));
        for (int i = 0; i < 20 && i < got_adx.size(); i++) begin
            chk("wrap_addr", 128'(got_adx[i]), 128'(27'(i * 37 + 5)));
        end

        // Reset while issuing with three queued
        app_rdy = 1'b0; app_wdf_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            write_req = 1'b1;
            dram_adx  = 27'h0000300 + 27'(i);
            step();
        end
        write_req = 1'b0;
        chk("mid_level", 128'(fifo_level), 128'(3));
        chk("mid_en", 128'(app_en), 128'(1));
        resetn = 1'b0;
        step();
        chk("mid_rst_en", 128'(app_en), 128'(0));
        chk("mid_rst_wren", 128'(app_wdf_wren), 128'(0));
        chk("mid_rst_level", 128'(fifo_level), 128'(0));
        chk("mid_rst_done", 128'(writes_done), 128'(0));
        chk("mid_rst_allowed", 128'(write_allowed), 128'(0));
        resetn = 1'b1;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dram_write_bridge.md
Name: dram_write_bridge

Overview:
- Sits directly downstream of the sample packer.
- Accepts one memory-width word plus address per packer `write_req` into a small queue.
- Issues each queued word to the DDR controller user (app) interface as a single-beat write: independent command and write-data handshakes.
- Generates the `write_allowed` back-pressure the packer consumes. Reports queue level, an overflow flag and a completed-write count.

Parameters:
- MEM_IF_WIDTH, 128, data width of packer word and app write-data bus.
- ADX_WIDTH, 27, address width of packer address and `app_addr`.
- FIFO_AW, 2, log2 of queue depth (depth = 4 entries).
- APP_CMD_WRITE, 3'b000, command code driven on `app_cmd`.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- resetn  input  1  synchronous, active-low reset.
- write_req  input  1  packer write strobe, one word per high cycle.
- dram_data  input  MEM_IF_WIDTH  packer data word.
- dram_adx  input  ADX_WIDTH  packer word address.
- write_allowed  output  1  high when a `write_req` this cycle will be accepted.
- init_calib_complete  input  1  controller calibration done.
- app_en  output  1  command valid.
- app_cmd  output  3  command code.
- app_addr  output  ADX_WIDTH  command address.
- app_rdy  input  1  controller accepts command this cycle.
- app_wdf_data  output  MEM_IF_WIDTH  write data.
- app_wdf_wren  output  1  write data valid.
- app_wdf_end  output  1  last beat of burst.
- app_wdf_mask  output  MEM_IF_WIDTH/8  byte mask, constant 0.
- app_wdf_rdy  input  1  controller accepts write data this cycle.
- fifo_level  output  FIFO_AW+1  entries queued.
- overflow  output  1  sticky: `write_req` seen while `write_allowed` low.
- writes_done  output  32  count of fully retired writes.

Behaviour:
- **Reset** (`resetn` low at an edge):
  - Queue emptied; queued entries are discarded, including a reset mid-issue.
  - Pointers, `fifo_level`, `overflow`, `writes_done`, `cmd_done` and `data_done` all go to 0.
  - State goes to WAIT_CALIB.
  - `app_en`, `app_wdf_wren`, `app_wdf_end` and `write_allowed` are 0.
  - `app_addr` and `app_wdf_data` are don't-care while their valids are low.
- **`write_allowed`** = (state != WAIT_CALIB) & (`fifo_level` < 2^FIFO_AW).
  - Decoded from registered state only; it does not rise in the same cycle as a pop from a full queue.
- **Push**: `write_req` & `write_allowed` at an edge writes {`dram_adx`, `dram_data`} at the write pointer.
  - `write_req` while `write_allowed` is low: word dropped, `overflow` set, and `overflow` stays set until reset.
- **States**:
  - WAIT_CALIB: to IDLE when `init_calib_complete` = 1.
  - IDLE: to ISSUE when `fifo_level` != 0.
  - ISSUE: to IDLE on the pop edge if the queue becomes empty; otherwise remain in ISSUE and move to the next head entry.
  - `init_calib_complete` falling after calibration is ignored.
- **ISSUE outputs** (head entry):
  - `app_en` = ~`cmd_done`, `app_cmd` = APP_CMD_WRITE, `app_addr` = head address.
  - `app_wdf_wren` = `app_wdf_end` = ~`data_done`, `app_wdf_data` = head data.
  - `cmd_done` sets on `app_en` & `app_rdy`; `data_done` sets on `app_wdf_wren` & `app_wdf_rdy`. The two are independent, either may complete first.
- **Pop** at the edge where both halves are complete (including both in the same cycle):
  - Read pointer advances, both flags clear, `writes_done` += 1 (wraps at 2^32).
  - Next entry is presented in the following cycle.
- **Simultaneous push and pop**: `fifo_level` unchanged; pointers wrap modulo depth.
- **Latency**: push at edge N into an empty queue in IDLE gives `app_en`/`app_wdf_wren` high in cycle N+1. With `app_rdy` = `app_wdf_rdy` = 1, throughput is one write every 2 cycles (ISSUE cycle, then pop edge).
- **Ordering**: strict FIFO. Addresses and data are passed unmodified.

Test Plan:
- **Reset with calib low.** Reset, `init_calib_complete` = 0, `write_req` pulse -> `write_allowed` = 0, `overflow` = 1, no `app_en`. Second reset -> `overflow` = 0.
- **Single write.** Calib high, push adx 0x0000040 data 0x0123..CDEF with `app_rdy` = `app_wdf_rdy` = 1 -> next cycle `app_en` = `app_wdf_wren` = 1, `app_addr` = 0x0000040; after pop `writes_done` = 1, `fifo_level` = 0.
- **Skewed handshakes.** `app_rdy` held 0 for 3 cycles, `app_wdf_rdy` = 1 -> data accepted first, `app_wdf_wren` drops. `app_en` is held until `app_rdy`, then pop. Repeat with data late.
- **Full queue.** Stall both ready inputs, push 4 words -> `fifo_level` = 4, `write_allowed` = 0. Fifth `write_req` -> `overflow` = 1 and word absent. Release readies -> 4 writes retire in push order with correct data.
- **Pointer wrap.** Continuous pushes every 2 cycles with readies high for 20 words -> addresses out match addresses in, `writes_done` = 20, no overflow.
- **Reset mid-issue.** Assert `resetn` = 0 during ISSUE with 3 queued -> next cycle `app_en` = 0, `fifo_level` = 0, `writes_done` = 0.
